// File: rtl/vector_reg_file_if.sv
// Bus bundle for vector_reg_file: full-vector write port, two read ports and the serial load stream.
// The per-element wr_mask signal exists only when VREG_MASK_EN is defined.
interface vector_reg_file_if #(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int NREGS = 8,
  parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
);
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [BITS-1:0] wr_data [N-1:0];
`ifdef VREG_MASK_EN
  logic [N-1:0]    wr_mask;
`endif
  logic [AW-1:0]   rd0_addr;
  logic [AW-1:0]   rd1_addr;
  logic [BITS-1:0] rd0_data [N-1:0];
  logic [BITS-1:0] rd1_data [N-1:0];
  logic            ld_start;
  logic [AW-1:0]   ld_addr;
  logic            ld_valid;
  logic [BITS-1:0] ld_data;
  logic            ld_ready;
  logic            ld_done;
  logic            busy;

  modport master (
    output wr_en, wr_addr, wr_data,
`ifdef VREG_MASK_EN
    output wr_mask,
`endif
    output rd0_addr, rd1_addr, ld_start, ld_addr, ld_valid, ld_data,
    input  rd0_data, rd1_data, ld_ready, ld_done, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
`ifdef VREG_MASK_EN
    input  wr_mask,
`endif
    input  rd0_addr, rd1_addr, ld_start, ld_addr, ld_valid, ld_data,
    output rd0_data, rd1_data, ld_ready, ld_done, busy
  );
endinterface

// File: rtl/vector_reg_file.sv
// Vector register file: NREGS vectors of N x BITS elements, parallel write, two registered
// write-first read ports and a serial element loader. Define VREG_MASK_EN for per-element wr_mask.
module vector_reg_file #(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int NREGS = 8
) (
  input logic              clk,
  input logic              rst_n,
  vector_reg_file_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [AW:0]   NREGS_V  = (AW + 1)'(NREGS);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [AW-1:0]   r_tgt;
  logic            r_done;
  logic [BITS-1:0] r_regs [NREGS-1:0][N-1:0];
  logic [BITS-1:0] r_rd0_p1 [N-1:0];
  logic [BITS-1:0] r_rd1_p1 [N-1:0];

  logic [BITS-1:0] w_next [NREGS-1:0][N-1:0];
  logic [N-1:0]    w_mask;
  logic            w_in_load;
  logic            w_wr_ok;
  logic            w_ld_acc;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_V);
  endfunction

`ifdef VREG_MASK_EN
  assign w_mask = bus.wr_mask;
`else
  assign w_mask = '1;
`endif

  // A parallel write aimed at the register being serially loaded is dropped so the stream owns it.
  assign w_in_load = (r_state == LOAD);
  assign w_wr_ok   = bus.wr_en && in_range(bus.wr_addr) && !(w_in_load && (bus.wr_addr == r_tgt));
  assign w_ld_acc  = w_in_load && bus.ld_valid;

  // Next-state view of the whole file; the read ports sample it, which gives write-first bypass.
  always_comb begin
    w_next = r_regs;
    for (int i = 0; i < N; i++) begin
      if (w_wr_ok && w_mask[i]) begin
        w_next[bus.wr_addr][i] = bus.wr_data[i];
      end
    end
    if (w_ld_acc && in_range(r_tgt)) begin
      w_next[r_tgt][r_idx] = bus.ld_data;
    end
  end

  // ---- storage and read stage p1 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        for (int i = 0; i < N; i++) begin
          r_regs[r][i] <= '0;
        end
      end
      for (int i = 0; i < N; i++) begin
        r_rd0_p1[i] <= '0;
        r_rd1_p1[i] <= '0;
      end
    end else begin
      r_regs <= w_next;
      for (int i = 0; i < N; i++) begin
        r_rd0_p1[i] <= in_range(bus.rd0_addr) ? w_next[bus.rd0_addr][i] : '0;
        r_rd1_p1[i] <= in_range(bus.rd1_addr) ? w_next[bus.rd1_addr][i] : '0;
      end
    end
  end

  // ---- serial load controller ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_tgt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.ld_start) begin
            r_state <= LOAD;
            r_tgt   <= bus.ld_addr;
            r_idx   <= '0;
          end
        end
        LOAD: begin
          if (bus.ld_valid) begin
            if (r_idx == LAST_IDX) begin
              r_state <= IDLE;
              r_idx   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd0_data = r_rd0_p1;
  assign bus.rd1_data = r_rd1_p1;
  assign bus.ld_ready = w_in_load;
  assign bus.busy     = w_in_load;
  assign bus.ld_done  = r_done;
endmodule

// File: tb/tb_vector_reg_file.sv
// Self-checking bench for vector_reg_file: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against an array-based model of the register file.
module tb_vector_reg_file;
  localparam int BITS  = 8;
  localparam int N     = 64;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_on = 1'b0;

  logic [BITS-1:0] m  [NREGS][N];
  logic [BITS-1:0] e0 [N];
  logic [BITS-1:0] e1 [N];
  bit   m_load = 1'b0;
  bit   m_done = 1'b0;
  int   m_tgt  = 0;
  int   m_cnt  = 0;

  vector_reg_file_if #(.BITS(BITS), .N(N), .NREGS(NREGS)) bus ();

  vector_reg_file #(.BITS(BITS), .N(N), .NREGS(NREGS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  function automatic bit mask_bit(input int i);
`ifdef VREG_MASK_EN
    return bus.wr_mask[i];
`else
    return 1'b1;
`endif
  endfunction

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // kind 0: every element = base; kind 1: element i = base+i; kind 2: even = base, odd = 0xFF
  task automatic lit_rd(input string name, input int port, input int kind, input int base);
    int bad = -1;
    logic [BITS-1:0] a, e, ga, ge;
    for (int i = 0; i < N; i++) begin
      a = (port == 0) ? bus.rd0_data[i] : bus.rd1_data[i];
      e = (kind == 0) ? BITS'(base) : (kind == 1) ? BITS'(base + i) :
          ((i % 2) == 0) ? BITS'(base) : 8'hFF;
      if (a !== e && bad < 0) begin
        bad = i; ga = a; ge = e;
      end
    end
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: element %0d got %0h, expected %0h", name, bad, ga, ge);
    end
  endtask

  // Model + per-cycle compare. At each falling edge the inputs are still those the DUT sampled
  // at the preceding rising edge, so the model advances one step and then checks the outputs.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      foreach (m[r, i]) m[r][i] = '0;
      foreach (e0[i]) begin e0[i] = '0; e1[i] = '0; end
      m_load = 1'b0; m_done = 1'b0; m_tgt = 0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (bus.wr_en && int'(bus.wr_addr) < NREGS && !(m_load && int'(bus.wr_addr) == m_tgt)) begin
        for (int i = 0; i < N; i++)
          if (mask_bit(i)) m[int'(bus.wr_addr)][i] = bus.wr_data[i];
      end
      if (m_load) begin
        if (bus.ld_valid) begin
          if (m_tgt < NREGS) m[m_tgt][m_cnt] = bus.ld_data;
          m_cnt++;
          if (m_cnt == N) begin m_load = 1'b0; m_cnt = 0; m_done = 1'b1; end
        end
      end else if (bus.ld_start) begin
        m_load = 1'b1; m_tgt = int'(bus.ld_addr); m_cnt = 0;
      end
      for (int i = 0; i < N; i++) begin
        e0[i] = (int'(bus.rd0_addr) < NREGS) ? m[int'(bus.rd0_addr)][i] : '0;
        e1[i] = (int'(bus.rd1_addr) < NREGS) ? m[int'(bus.rd1_addr)][i] : '0;
      end
    end
    if (chk_on) begin
      int b0 = -1, b1 = -1;
      n_vec += 5;
      if (bus.busy !== m_load) begin
        n_err++; $display("FAIL busy @%0t: got %b, expected %b", $time, bus.busy, m_load);
      end
      if (bus.ld_ready !== m_load) begin
        n_err++; $display("FAIL ld_ready @%0t: got %b, expected %b", $time, bus.ld_ready, m_load);
      end
      if (bus.ld_done !== m_done) begin
        n_err++; $display("FAIL ld_done @%0t: got %b, expected %b", $time, bus.ld_done, m_done);
      end
      for (int i = 0; i < N; i++) begin
        if (bus.rd0_data[i] !== e0[i] && b0 < 0) b0 = i;
        if (bus.rd1_data[i] !== e1[i] && b1 < 0) b1 = i;
      end
      if (b0 >= 0) begin
        n_err++;
        $display("FAIL rd0_data @%0t: element %0d got %0h, expected %0h", $time, b0, bus.rd0_data[b0], e0[b0]);
      end
      if (b1 >= 0) begin
        n_err++;
        $display("FAIL rd1_data @%0t: element %0d got %0h, expected %0h", $time, b1, bus.rd1_data[b1], e1[b1]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_en = 1'b0; bus.wr_addr = '0;
    for (int i = 0; i < N; i++) bus.wr_data[i] = '0;
`ifdef VREG_MASK_EN
    bus.wr_mask = '1;
`endif
    bus.rd0_addr = '0; bus.rd1_addr = '0;
    bus.ld_start = 1'b0; bus.ld_addr = '0; bus.ld_valid = 1'b0; bus.ld_data = '0;
  endtask

  task automatic fill(input int addr, input int val);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(addr);
    for (int i = 0; i < N; i++) bus.wr_data[i] = BITS'(val);
  endtask

  // Streams N elements base+i; stall>0 drops ld_valid every stall-th cycle; wr_mix injects
  // a parallel write to the load target and one to reg4 mid-stream.
  task automatic do_load(input int addr, input int base, input int stall, input bit wr_mix,
                         input string name, output int dones);
    int i = 0;
    dones = 0;
    bus.ld_start = 1'b1; bus.ld_addr = AW'(addr);
    tick();
    bus.ld_start = 1'b0;
    lit({name, " busy after start"}, 32'(bus.busy), 32'd1);
    for (int c = 0; c < 4 * N && i < N; c++) begin
      bus.ld_valid = (stall == 0) || ((c % stall) != stall - 1);
      bus.ld_data  = BITS'(base + i);
      bus.ld_start = bus.ld_valid && (i == N - 1);
      bus.wr_en    = 1'b0;
      if (wr_mix && c == 4) fill(addr, 8'h55);
      if (wr_mix && c == 5) fill(4, 8'h66);
      tick();
      if (bus.ld_valid) i++;
      if (bus.ld_done) dones++;
    end
    if (i < N) lit({name, " stream timeout"}, 32'(i), 32'(N));
    idle_in();
    repeat (3) begin
      tick();
      if (bus.ld_done) dones++;
    end
    lit({name, " busy after done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int dones;
    idle_in();
    tick();
    chk_on = 1'b1;
    tick();
    lit("reset busy", 32'(bus.busy), 32'd0);
    lit("reset ld_done", 32'(bus.ld_done), 32'd0);
    lit_rd("reset rd0", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // reg3 = {i}, read back on rd0 while rd1 watches an untouched register
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3;
    for (int i = 0; i < N; i++) bus.wr_data[i] = BITS'(i);
    bus.rd0_addr = 3'd3; bus.rd1_addr = 3'd0;
    tick();
    bus.wr_en = 1'b0;
    tick();
    lit_rd("reg3 ramp rd0", 0, 1, 0);
    lit_rd("reg3 rd1 untouched", 1, 0, 0);

    // same-cycle write and read of reg5 must bypass
    fill(5, 8'hAA); bus.rd0_addr = 3'd5;
    tick();
    lit_rd("reg5 bypass", 0, 0, 8'hAA);
    bus.wr_en = 1'b0;

    do_load(2, 8'h10, 3, 1'b0, "load reg2", dones);
    lit("load reg2 ld_done pulses", 32'(dones), 32'd1);
    bus.rd1_addr = 3'd2;
    tick();
    lit_rd("reg2 streamed", 1, 1, 8'h10);

    do_load(2, 8'h30, 0, 1'b1, "load reg2 mix", dones);
    lit("mix ld_done pulses", 32'(dones), 32'd1);
    bus.rd0_addr = 3'd2; bus.rd1_addr = 3'd4;
    tick();
    lit_rd("reg2 stream wins", 0, 1, 8'h30);
    lit_rd("reg4 written during load", 1, 0, 8'h66);

    // reset part-way through a load
    bus.ld_start = 1'b1; bus.ld_addr = 3'd6;
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = BITS'(8'h40 + i);
      tick();
    end
    idle_in();
    rst_n = 1'b0;
    tick();
    lit("busy in reset", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    repeat (3) begin
      tick();
      if (bus.ld_done) dones++;
    end
    lit("no done after abort", 32'(dones), 32'd0);
    bus.rd0_addr = 3'd3; bus.rd1_addr = 3'd6;
    tick();
    lit_rd("reg3 cleared", 0, 0, 0);
    lit_rd("reg6 cleared", 1, 0, 0);
    do_load(7, 8'h50, 0, 1'b0, "load reg7", dones);
    lit("reg7 ld_done pulses", 32'(dones), 32'd1);
    bus.rd0_addr = 3'd7;
    tick();
    lit_rd("reg7 streamed", 0, 1, 8'h50);

`ifdef VREG_MASK_EN
    fill(1, 8'hFF);
    tick();
    fill(1, 8'h00);
    for (int i = 0; i < N; i++) bus.wr_mask[i] = ((i % 2) == 0);
    bus.rd0_addr = 3'd1;
    tick();
    idle_in(); bus.rd0_addr = 3'd1;
    tick();
    lit_rd("reg1 masked", 0, 2, 8'h00);
`endif

    for (int c = 0; c < 3000; c++) begin
      bus.wr_en = ($urandom_range(0, 2) == 0);
      bus.wr_addr = (m_load && $urandom_range(0, 1) == 1) ? AW'(m_tgt) : AW'($urandom_range(0, NREGS - 1));
      for (int i = 0; i < N; i++) bus.wr_data[i] = BITS'($urandom);
`ifdef VREG_MASK_EN
      bus.wr_mask = N'({$urandom, $urandom});
`endif
      bus.rd0_addr = AW'($urandom_range(0, NREGS - 1));
      bus.rd1_addr = AW'($urandom_range(0, NREGS - 1));
      bus.ld_start = ($urandom_range(0, 19) == 0);
      bus.ld_addr  = AW'($urandom_range(0, NREGS - 1));
      bus.ld_valid = ($urandom_range(0, 3) != 0);
      bus.ld_data  = BITS'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    idle_in();
    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
